// File: rtl/store_lane_buffer_pkg.sv
// Shared opcode field, store opcodes and lane constants for the store lane buffer.
// Imported by the lane encoder and by the buffer top level.
package store_lane_buffer_pkg;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int OP_W   = OP_MSB - OP_LSB + 1;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [OP_W-1:0] OP_SB = 6'h28;
  localparam logic [OP_W-1:0] OP_SH = 6'h29;
  localparam logic [OP_W-1:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_BYTE,
    ST_HALF,
    ST_WORD
  } st_size_e;

  function automatic st_size_e decode_size(input logic [OP_W-1:0] op);
    case (op)
      OP_SB:   return ST_BYTE;
      OP_SH:   return ST_HALF;
      OP_SW:   return ST_WORD;
      default: return ST_NONE;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_buffer_encode.sv
// Combinational store narrowing: replicates SB/SH/SW data into big-endian
// byte lanes, builds byte enables and flags misaligned or non-store opcodes.
module store_lane_encode
  import store_lane_buffer_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic              misaligned,
  output logic              illegal
);

  // Lane 3 (bits 31:24) holds byte offset 0, so enables shift right with offset.
  always_comb begin
    wdata      = '0;
    be         = '0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (decode_size(op))
      ST_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b1000 >> addr_lo;
      end
      ST_HALF: begin
        if (addr_lo[0]) begin
          misaligned = 1'b1;
        end else begin
          wdata = {2{data[15:0]}};
          be    = addr_lo[1] ? 4'b0011 : 4'b1100;
        end
      end
      ST_WORD: begin
        if (addr_lo != 2'b00) begin
          misaligned = 1'b1;
        end else begin
          wdata = data;
          be    = 4'b1111;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_lane_buffer.sv
// Store buffer: encodes MEM-stage stores into lanes and queues them in a FIFO
// that drains to data memory over valid/ready, so stores retire without stalling.
module store_lane_buffer
  import store_lane_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_instr,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_misaligned,
  output logic                     st_illegal,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [BE_W-1:0]          mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [ADDR_W-1:0] addr_d  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [DATA_W-1:0] wdata_d [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [BE_W-1:0]   be_d    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             misaligned_q, misaligned_d;
  logic             illegal_q, illegal_d;

  logic [DATA_W-1:0] enc_wdata;
  logic [BE_W-1:0]   enc_be;
  logic              enc_misaligned;
  logic              enc_illegal;
  logic              accept;
  logic              push;
  logic              pop;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^st_instr[OP_LSB-1:0];

  store_lane_encode u_encode (
    .op         (st_instr[OP_MSB:OP_LSB]),
    .addr_lo    (st_addr[1:0]),
    .data       (st_data),
    .wdata      (enc_wdata),
    .be         (enc_be),
    .misaligned (enc_misaligned),
    .illegal    (enc_illegal)
  );

  // Readiness comes from the registered full flag only, so a pop never frees a slot same-cycle.
  assign accept = st_valid && !full_q;
  assign push   = accept && !enc_misaligned && !enc_illegal;
  assign pop    = !empty_q && mem_ready;

  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    misaligned_d = accept && enc_misaligned;
    illegal_d    = accept && enc_illegal;

    if (push) begin
      addr_d[wr_ptr_q]  = {st_addr[ADDR_W-1:2], 2'b00};
      wdata_d[wr_ptr_q] = enc_wdata;
      be_d[wr_ptr_q]    = enc_be;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
    end
  end

  assign st_ready      = !full_q;
  assign mem_valid     = !empty_q;
  assign mem_addr      = addr_q[rd_ptr_q];
  assign mem_wdata     = wdata_q[rd_ptr_q];
  assign mem_be        = be_q[rd_ptr_q];
  assign count         = count_q;
  assign empty         = empty_q;
  assign st_misaligned = misaligned_q;
  assign st_illegal    = illegal_q;

endmodule

// File: tb/tb_store_lane_buffer.sv
// Directed self-checking bench for store_lane_buffer: lane encoding, alignment
// and opcode errors, backpressure, full-with-pop, pointer wrap and async reset.
module tb_store_lane_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_instr;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misaligned;
  logic        st_illegal;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
  logic        empty;

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] OpSb = 6'h28;
  localparam logic [5:0] OpSh = 6'h29;
  localparam logic [5:0] OpSw = 6'h2B;
  localparam logic [5:0] OpLw = 6'h23;

  store_lane_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_instr      (st_instr),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_misaligned (st_misaligned),
    .st_illegal    (st_illegal),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_be        (mem_be),
    .count         (count),
    .empty         (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the clock stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one store request; it is sampled at the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [5:0] op, input logic [31:0] addr,
                               input logic [31:0] data);
    st_valid = valid;
    st_instr = {op, 26'h0};
    st_addr  = addr;
    st_data  = data;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    applyStimulus(1'b0, 6'h0, 32'h0, 32'h0);
    #12;
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_st_ready", 32'(st_ready), 32'd1);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
    checkOutput("rst_misaligned", 32'(st_misaligned), 32'd0);
    checkOutput("rst_illegal", 32'(st_illegal), 32'd0);
    rst_n = 1'b1;
    stepCycle();

    // SB at offset 3 lands in the least-significant lane.
    mem_ready = 1'b1;
    applyStimulus(1'b1, OpSb, 32'h0000_1003, 32'h1234_56A5);
    stepCycle();
    applyStimulus(1'b0, OpSb, 32'h0, 32'h0);
    checkOutput("sb_valid", 32'(mem_valid), 32'd1);
    checkOutput("sb_addr", mem_addr, 32'h0000_1000);
    checkOutput("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    checkOutput("sb_be", 32'(mem_be), 32'h1);
    checkOutput("sb_count", 32'(count), 32'd1);
    stepCycle();
    checkOutput("sb_popped_empty", 32'(empty), 32'd1);
    checkOutput("sb_popped_count", 32'(count), 32'd0);

    // SB at offset 0 uses the most-significant lane.
    mem_ready = 1'b0;
    applyStimulus(1'b1, OpSb, 32'h0000_3000, 32'h0000_0077);
    stepCycle();
    applyStimulus(1'b0, OpSb, 32'h0, 32'h0);
    checkOutput("sb0_be", 32'(mem_be), 32'h8);
    checkOutput("sb0_wdata", mem_wdata, 32'h7777_7777);
    mem_ready = 1'b1;
    stepCycle();
    mem_ready = 1'b0;

    // SH upper half, then misaligned SH.
    applyStimulus(1'b1, OpSh, 32'h0000_2002, 32'h1234_BEEF);
    stepCycle();
    checkOutput("sh_addr", mem_addr, 32'h0000_2000);
    checkOutput("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    checkOutput("sh_be", 32'(mem_be), 32'h3);
    applyStimulus(1'b1, OpSh, 32'h0000_2001, 32'h1234_BEEF);
    stepCycle();
    applyStimulus(1'b0, OpSh, 32'h0, 32'h0);
    checkOutput("shmis_pulse", 32'(st_misaligned), 32'd1);
    checkOutput("shmis_count", 32'(count), 32'd1);
    checkOutput("shmis_head_kept", mem_addr, 32'h0000_2000);
    stepCycle();
    checkOutput("shmis_pulse_end", 32'(st_misaligned), 32'd0);
    mem_ready = 1'b1;
    stepCycle();
    checkOutput("sh_drained", 32'(empty), 32'd1);

    // Fill with SW under backpressure, fifth request refused.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, OpSw, 32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      stepCycle();
    end
    checkOutput("fill_count", 32'(count), 32'd4);
    checkOutput("fill_ready", 32'(st_ready), 32'd0);
    applyStimulus(1'b1, OpSw, 32'h20, 32'hDEAD_0000);
    stepCycle();
    checkOutput("fill_refused", 32'(count), 32'd4);
    applyStimulus(1'b0, OpSw, 32'h0, 32'h0);
    checkOutput("drain_addr0", mem_addr, 32'h10);
    checkOutput("drain_be0", 32'(mem_be), 32'hF);
    checkOutput("drain_data0", mem_wdata, 32'hC0DE_0000);
    mem_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      stepCycle();
      checkOutput("drain_addr", mem_addr, 32'h10 + 32'(4 * i));
      checkOutput("drain_data", mem_wdata, 32'hC0DE_0000 + 32'(i));
    end
    stepCycle();
    checkOutput("drain_empty", 32'(empty), 32'd1);

    // Full plus pop plus push in one cycle: only the pop happens.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, OpSw, 32'h40 + 32'(4 * i), 32'h0);
      stepCycle();
    end
    applyStimulus(1'b1, OpSw, 32'h50, 32'h0);
    mem_ready = 1'b1;
    stepCycle();
    checkOutput("fullpp_count", 32'(count), 32'd3);
    checkOutput("fullpp_head", mem_addr, 32'h44);
    stepCycle();
    applyStimulus(1'b0, OpSw, 32'h0, 32'h0);
    checkOutput("fullpp_push_count", 32'(count), 32'd3);
    checkOutput("fullpp_push_head", mem_addr, 32'h48);
    stepCycle();
    checkOutput("fullpp_tail1", mem_addr, 32'h4C);
    stepCycle();
    checkOutput("fullpp_tail2", mem_addr, 32'h50);
    stepCycle();
    checkOutput("fullpp_empty", 32'(empty), 32'd1);

    // Continuous stream through pointer wrap keeps one entry in flight.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, OpSw, 32'h100 + 32'(4 * i), 32'(i));
      stepCycle();
      checkOutput("wrap_count", 32'(count), 32'd1);
      checkOutput("wrap_valid", 32'(mem_valid), 32'd1);
      checkOutput("wrap_addr", mem_addr, 32'h100 + 32'(4 * i));
    end
    applyStimulus(1'b0, OpSw, 32'h0, 32'h0);
    stepCycle();
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Non-store opcode is flagged and dropped.
    applyStimulus(1'b1, OpLw, 32'h0000_4000, 32'h1);
    stepCycle();
    applyStimulus(1'b0, OpLw, 32'h0, 32'h0);
    checkOutput("ill_pulse", 32'(st_illegal), 32'd1);
    checkOutput("ill_count", 32'(count), 32'd0);
    checkOutput("ill_misaligned", 32'(st_misaligned), 32'd0);
    stepCycle();
    checkOutput("ill_pulse_end", 32'(st_illegal), 32'd0);

    // Asynchronous reset mid-cycle discards queued entries at once.
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, OpSw, 32'h200 + 32'(4 * i), 32'h0);
      stepCycle();
    end
    applyStimulus(1'b0, OpSw, 32'h0, 32'h0);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(mem_valid), 32'd0);
    checkOutput("arst_count", 32'(count), 32'd0);
    checkOutput("arst_empty", 32'(empty), 32'd1);
    checkOutput("arst_addr", mem_addr, 32'h0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_lane_buffer.md
Name: store_lane_buffer

Overview:
- Write-side counterpart of the load/immediate extension path. Takes SB/SH/SW requests from the MEM stage and narrows rt data from 32 bits to 8/16/32.
- Replicates the narrowed data into big-endian byte lanes, generates byte enables, and queues the result in a small FIFO.
- Drains the FIFO to data memory over a valid/ready handshake.
- Lets the pipeline retire stores without stalling on memory latency. Provides an empty flag for sync/drain.

Parameters:
- DEPTH, 4, number of FIFO entries (power of 2, ≥2).
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- st_valid  input  1  store request present.
- st_ready  output  1  buffer can accept; equals !full.
- st_instr  input  32  instruction word; opcode at `op field.
- st_addr  input  ADDR_W  effective byte address.
- st_data  input  32  rt register value.
- st_misaligned  output  1  one-cycle pulse: accepted request had bad alignment, dropped.
- st_illegal  output  1  one-cycle pulse: accepted opcode not SB/SH/SW, dropped.
- mem_valid  output  1  head entry valid; equals !empty.
- mem_ready  input  1  memory accepts head.
- mem_addr  output  ADDR_W  word-aligned address (low 2 bits 0).
- mem_wdata  output  32  lane-replicated data.
- mem_be  output  4  byte enables; bit3 = bits 31:24.
- count  output  log2(DEPTH)+1  entries held.
- empty  output  1  count==0.

Behaviour:
- **Reset.** While rst_n is low: pointers and count are 0, and storage is cleared to 0. Outputs: mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, st_misaligned=0, st_illegal=0, empty=1, st_ready=1.
- **Accept.** A request is accepted on a rising edge with st_valid && st_ready.
- **Ready rule.** st_ready depends only on full, never on mem_ready. When full, a same-cycle pop does not free a slot for a push.
- **Lane encoding (big-endian).** Byte offset o = addr[1:0].
  - SB: wdata = {4{data[7:0]}}, be = 4'b1000 >> o.
  - SH: legal only if addr[0]=0. wdata = {2{data[15:0]}}, be = 4'b1100 when o=0, 4'b0011 when o=2.
  - SW: legal only if o=0. wdata = data, be = 4'b1111.
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
- **Misaligned.** An accepted SH with addr[0]=1, or an accepted SW with o≠0: nothing is written to the FIFO. st_misaligned pulses high in the next cycle.
- **Illegal.** An accepted non-store opcode: nothing is written to the FIFO. st_illegal pulses high in the next cycle.
- **Latency.** An entry pushed at edge N is visible on mem_* after edge N. There is no combinational bypass, even when the FIFO is empty.
- **Drain.** The head is popped on a rising edge with mem_valid && mem_ready. The mem_* outputs hold stable while mem_valid && !mem_ready.
- **Simultaneous push and pop** (not full, not empty): count is unchanged and both pointers advance.
- **Pointer wrap.** Pointers wrap modulo DEPTH. Full is count==DEPTH and empty is count==0; no pointer-MSB comparison.
- **Ordering.** Entries drain strictly in acceptance order. There is no merging or coalescing.
- **Reset mid-operation.** All queued entries are discarded immediately on assertion of rst_n low. There is no partial write completion.
- **Storage.** Per-entry stored fields: word address, wdata, be.
- **Control.** No internal FSM beyond FIFO control. count, empty and full are registered state.

Decomposition:
- **Shared defines/package** (alongside the existing `op field and opcode defines): SB=6'h28, SH=6'h29, SW=6'h2B, plus a BE_W=4 constant.
- **Sub-module store_lane_encode** (combinational): opcode, addr[1:0], data in; wdata, be, misaligned, illegal out.
- The top level holds the FIFO, pointers, count, and pulse registers.

Test Plan:
- **SB.** SB, addr 0x00001003, data 0x123456A5, mem_ready=1 → next cycle mem_addr=0x00001000, wdata=0xA5A5A5A5, be=4'b0001. Pops the following edge.
- **SH and misaligned SH.** SH addr 0x00002002, data 0x1234BEEF → wdata=0xBEEFBEEF, be=4'b0011. Then SH addr 0x00002001 → st_misaligned pulses 1 cycle, count unchanged.
- **Fill and backpressure.** mem_ready=0, push 4 SW (0x10,0x14,0x18,0x1C) → st_ready=0 and count=4. A 5th st_valid is not accepted. Raise mem_ready → drained in order 0x10..0x1C, empty=1 after 4 edges.
- **Full with simultaneous events.** Full with mem_ready=1 and st_valid=1 in the same cycle → pop occurs, push does not, count=3. Next cycle the push is accepted.
- **Steady-state wrap.** mem_ready=1, continuous SW stream of 10 entries → count stays 1, mem_valid stays 1, addresses emerge in order through pointer wrap.
- **Illegal opcode and reset.** st_instr opcode 6'h23 (LW) → st_illegal pulse, no push. Then queue 2 entries and assert rst_n low asynchronously mid-cycle → mem_valid=0 and count=0 immediately.
